cache_nway_burst: RTL and testbench

//  Read-only N-way set-associative cache with multi-word lines and burst refill. Sits between a core

---
 rtl/cache_nway_burst.sv | 144 ++++++++++++++
 tb/tb_cache_nway_burst.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_burst.sv
// Read-only N-way set-associative cache with multi-word lines, burst refill,
// per-set round-robin replacement and a whole-cache flush.
module cache_nway_burst #(
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        core_read,
  input  logic [31:0] core_address,
  output logic        core_waitrequest,
  output logic [31:0] core_readdata,
  output logic        core_readdatavalid,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_burstcount,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);
  localparam int WORDS = LINE_BYTES / 4;
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int TW    = 32 - OFF - IDX;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_e;
  state_e state_q, state_d;

  logic [31:0]               addr_q;
  logic [WB-1:0]             victim_q;
  logic [WW-1:0]             beat_q;
  logic                      flush_pend_q;
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WB-1:0]   rr_q;
  logic [TW-1:0]             tag_mem  [WAYS][SETS];
  logic [31:0]               data_mem [WAYS][SETS][WORDS];

  logic [IDX-1:0] idx;
  logic [TW-1:0]  tag;
  logic [WW-1:0]  word;
  logic           unused_addr;
  assign idx         = addr_q[OFF +: IDX];
  assign tag         = addr_q[31 -: TW];
  assign word        = (WORDS > 1) ? WW'(addr_q[31:2]) : '0;
  assign unused_addr = ^addr_q[1:0];

  logic          hit, any_inv;
  logic [WB-1:0] hit_way, inv_way, victim, rr_inc;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_mem[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[idx][w]) begin
        any_inv = 1'b1;
        inv_way = WB'(w);
      end
    end
    victim = any_inv ? inv_way : rr_q[idx];
    rr_inc = (rr_q[idx] == WB'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
  end

  logic accept, lk_miss, last_beat, fill_beat, fill_last, flush_now;
  assign accept    = core_read && !core_waitrequest;
  assign lk_miss   = (state_q == LOOKUP) && !hit;
  assign last_beat = (beat_q == WW'(WORDS - 1));
  assign fill_beat = (state_q == FILL) && mem_readdatavalid;
  assign fill_last = fill_beat && last_beat;
  assign flush_now = flush && ((state_q == IDLE) || (state_q == LOOKUP && hit));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  if (!hit) state_d = REQ;
               else if (!accept) state_d = IDLE;
      REQ:     if (!mem_waitrequest) state_d = FILL;
      FILL:    if (fill_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_waitrequest   = 1'b1;
    core_readdatavalid = 1'b0;
    core_readdata      = data_mem[victim_q][idx][word];
    mem_read           = 1'b0;
    case (state_q)
      IDLE:    core_waitrequest = 1'b0;
      LOOKUP:  if (hit) begin
                 core_waitrequest   = 1'b0;
                 core_readdatavalid = 1'b1;
                 core_readdata      = data_mem[hit_way][idx][word];
               end
      REQ:     mem_read = 1'b1;
      RESP:    core_readdatavalid = 1'b1;
      default: ;
    endcase
  end

  assign mem_address    = {tag, idx, {OFF{1'b0}}};
  assign mem_burstcount = 8'(WORDS);

  // Arrays and address/beat bookkeeping need no reset.
  always_ff @(posedge clk) begin
    if (accept) addr_q <= core_address;
    if (lk_miss) victim_q <= victim;
    if (state_q == REQ) beat_q <= '0;
    else if (fill_beat) beat_q <= beat_q + 1'b1;
    if (fill_beat) data_mem[victim_q][idx][beat_q] <= mem_readdata;
    if (fill_last) tag_mem[victim_q][idx] <= tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rr_q         <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (lk_miss && !any_inv) rr_q[idx] <= rr_inc;
      if (fill_last) valid_q[idx][victim_q] <= 1'b1;
      // A flush seen during a refill is deferred to the RESP->IDLE edge.
      if (flush_now || (state_q == RESP && (flush_pend_q || flush))) valid_q <= '0;
      if (state_q == RESP) flush_pend_q <= 1'b0;
      else if (flush && !flush_now) flush_pend_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_nway_burst.sv
// Directed bench for cache_nway_burst: vector table of reads plus hand-written
// sequences for back-to-back hits, memory stall, flush and reset mid-refill.
module tb_cache_nway_burst;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst, flush, core_read;
  logic [31:0] core_address;
  logic        core_waitrequest, core_readdatavalid;
  logic [31:0] core_readdata;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [7:0]  mem_burstcount;
  logic        mem_waitrequest, mem_readdatavalid;
  logic [31:0] mem_readdata;

  always #5 clk = ~clk;

  cache_nway_burst #(.LINE_BYTES(16), .SETS(32), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .core_read(core_read), .core_address(core_address),
    .core_waitrequest(core_waitrequest), .core_readdata(core_readdata),
    .core_readdatavalid(core_readdatavalid),
    .mem_read(mem_read), .mem_address(mem_address), .mem_burstcount(mem_burstcount),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  int total = 0, bad = 0;
  int bursts = 0, stall_cfg = 0, req_cnt = 0, last_req_cycles = 0;
  int beats_left = 0, beat_idx = 0;
  logic [31:0] burst_addr = '0, req_addr = '0;
  bit addr_moved = 1'b0, bc_bad = 1'b0;

  // Memory image: every word holds 0xA5 in the top byte and its own address below.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  initial begin : responder
    mem_waitrequest = 1'b1; mem_readdatavalid = 1'b0; mem_readdata = '0;
    forever begin
      @(negedge clk);
      mem_readdatavalid = 1'b0;
      mem_waitrequest   = 1'b1;
      if (beats_left > 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = memword(burst_addr + 32'(4 * beat_idx));
        beat_idx++;
        beats_left--;
      end else if (mem_read) begin
        if (req_cnt == 0) req_addr = mem_address;
        else if (mem_address !== req_addr) addr_moved = 1'b1;
        if (mem_burstcount !== 8'd4) bc_bad = 1'b1;
        req_cnt++;
        if (req_cnt > stall_cfg) begin
          mem_waitrequest = 1'b0;
          last_req_cycles = req_cnt;
          req_cnt         = 0;
          burst_addr      = mem_address;
          beats_left      = WORDS;
          beat_idx        = 0;
          bursts++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp, input bit miss);
    int b0, n;
    b0 = bursts;
    n  = 0;
    core_read = 1'b1; core_address = a;
    while (core_waitrequest && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    core_read = 1'b0;
    n = 1;
    while (!core_readdatavalid && n < 100) begin @(negedge clk); n++; end
    if (!core_readdatavalid) timeout(nm);
    else begin
      chk({nm, "_data"}, core_readdata, exp);
      chk({nm, "_miss"}, 32'(bursts - b0), 32'(miss));
      if (miss) chk({nm, "_maddr"}, burst_addr, a & 32'hFFFF_FFF0);
      else      chk({nm, "_lat"}, 32'(n), 32'd1);
    end
    @(negedge clk);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] exp;
    bit          miss;
  } vec_t;
  vec_t vq[$];

  task automatic add(input string nm, input logic [31:0] a, input logic [31:0] e, input bit m);
    vec_t t;
    t.nm = nm; t.a = a; t.exp = e; t.miss = m;
    vq.push_back(t);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] b2b_exp [4];
    int b0, n, seen;
    b2b_exp = '{32'hA500_0100, 32'hA500_0104, 32'hA500_0108, 32'hA500_010C};

    // Set 0 holds 0x000/0x200/0x400 lines; exercises fill-invalid then round-robin.
    add("cold100",  32'h100, 32'hA500_0100, 1);
    add("hit104",   32'h104, 32'hA500_0104, 0);
    add("hit10C",   32'h10C, 32'hA500_010C, 0);
    add("cold000",  32'h000, 32'hA500_0000, 1);
    add("cold204",  32'h204, 32'hA500_0204, 1);
    add("hit00C",   32'h00C, 32'hA500_000C, 0);
    add("cold408",  32'h408, 32'hA500_0408, 1);
    add("hit208",   32'h208, 32'hA500_0208, 0);
    add("hit404",   32'h404, 32'hA500_0404, 0);
    add("re004",    32'h004, 32'hA500_0004, 1);
    add("re200",    32'h200, 32'hA500_0200, 1);
    add("hit008",   32'h008, 32'hA500_0008, 0);

    rst = 1'b1; flush = 1'b0; core_read = 1'b0; core_address = '0;
    repeat (3) @(negedge clk);
    chk("rst_wait",  32'(core_waitrequest), 32'd0);
    chk("rst_rdv",   32'(core_readdatavalid), 32'd0);
    chk("rst_mread", 32'(mem_read), 32'd0);
    chk("burstcnt",  32'(mem_burstcount), 32'd4);
    rst = 1'b0;
    @(negedge clk);

    foreach (vq[i]) rd(vq[i].nm, vq[i].a, vq[i].exp, vq[i].miss);

    // Back-to-back hits on the 0x100 line, one per cycle.
    b0 = bursts;
    core_read = 1'b1; core_address = 32'h100;
    chk("b2b_wait0", 32'(core_waitrequest), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_rdv%0d", i),  32'(core_readdatavalid), 32'd1);
      chk($sformatf("b2b_data%0d", i), core_readdata, b2b_exp[i]);
      chk($sformatf("b2b_wait%0d", i), 32'(core_waitrequest), 32'd0);
      if (i < 3) core_address = 32'h100 + 32'(4 * (i + 1));
      else       core_read = 1'b0;
    end
    @(negedge clk);
    chk("b2b_rdv_end", 32'(core_readdatavalid), 32'd0);
    chk("b2b_nomem",   32'(bursts - b0), 32'd0);

    // Memory holds off the burst request for 5 cycles.
    stall_cfg = 5; addr_moved = 1'b0;
    rd("stall714", 32'h714, 32'hA500_0714, 1);
    stall_cfg = 0;
    chk("stall_cycles", 32'(last_req_cycles), 32'd6);
    chk("stall_addr",   32'(addr_moved), 32'd0);
    chk("stall_bcnt",   32'(bc_bad), 32'd0);

    // Flush alongside a LOOKUP hit: data still returned, line gone afterwards.
    core_read = 1'b1; core_address = 32'h718;
    @(negedge clk);
    core_read = 1'b0; flush = 1'b1;
    chk("hflush_rdv",  32'(core_readdatavalid), 32'd1);
    chk("hflush_data", core_readdata, 32'hA500_0718);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rd("hflush_re714", 32'h714, 32'hA500_0714, 1);

    // Flush during FILL of 0x100: data returned, then the line must be refetched.
    b0 = bursts;
    core_read = 1'b1; core_address = 32'h100;
    @(negedge clk);
    core_read = 1'b0;
    n = 0;
    while (bursts == b0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (!core_readdatavalid && n < 50) begin @(negedge clk); n++; end
    if (!core_readdatavalid) timeout("fflush_resp");
    else chk("fflush_data", core_readdata, 32'hA500_0100);
    chk("fflush_bursts", 32'(bursts - b0), 32'd1);
    @(negedge clk);
    rd("fflush_re100", 32'h100, 32'hA500_0100, 1);

    // Flush in IDLE.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rd("iflush_104", 32'h104, 32'hA500_0104, 1);

    // Reset after two of four refill beats; leftover beats must be ignored.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    b0 = bursts;
    core_read = 1'b1; core_address = 32'h100;
    @(negedge clk);
    core_read = 1'b0;
    n = 0;
    while (!(bursts > b0 && beat_idx == 2) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("mrst_wait_beats");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_wait",  32'(core_waitrequest), 32'd0);
    chk("mrst_rdv",   32'(core_readdatavalid), 32'd0);
    chk("mrst_mread", 32'(mem_read), 32'd0);
    seen = 0; n = 0;
    while (beats_left > 0 && n < 20) begin
      @(negedge clk);
      if (core_readdatavalid) seen++;
      n++;
    end
    @(negedge clk);
    if (core_readdatavalid) seen++;
    chk("mrst_stale", 32'(seen), 32'd0);
    rd("mrst_re100",  32'h100, 32'hA500_0100, 1);
    rd("mrst_hit10C", 32'h10C, 32'hA500_010C, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
